// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: receiver FSM state encoding, parity type
// constants and the parity helper that the TX parity logic also uses.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest data word the parity helper accepts. Callers zero-extend their
    // word to this width; zero padding does not change an XOR reduction.
    localparam int PARITY_MAX_WIDTH = 32;

    // Even: parity bit = ^data. Odd: parity bit = ~^data.
    function automatic logic calc_parity(input logic [PARITY_MAX_WIDTH-1:0] data,
                                         input logic                        typ);
        logic result;
        case (typ)
            PAR_EVEN: result = ^data;
            PAR_ODD:  result = ~^data;
            default:  result = ^data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_bit_sampler
// Per-bit timing for the UART receiver: edge counter (0..PRESCALE-1),
// three-point mid-bit capture and 2-of-3 majority vote.
//
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   rx_s         synchronised serial line
//   count_en     advance the edge counter this cycle (else it is held at 0)
//   clear        force the edge counter back to 0 (start-bit glitch abort)
//   sample_done  strobe: sample_bit holds the voted value of the current bit
//   sample_bit   2-of-3 majority of the three mid-bit samples
//   bit_end      strobe: last clock of the current bit (edge_cnt = PRESCALE-1)
// -----------------------------------------------------------------------------
module uart_rx_bit_sampler #(
    parameter int PRESCALE = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic rx_s,
    input  logic count_en,
    input  logic clear,
    output logic sample_done,
    output logic sample_bit,
    output logic bit_end
);

    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_CAP2 = CNT_W'(PRESCALE / 2 + 1);

    logic [CNT_W-1:0] edge_cnt_reg;
    logic [1:0]       early_sample_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt_reg <= '0;
        end else if (clear || !count_en) begin
            edge_cnt_reg <= '0;
        end else if (edge_cnt_reg == CNT_LAST) begin
            edge_cnt_reg <= '0;
        end else begin
            edge_cnt_reg <= edge_cnt_reg + 1'b1;
        end
    end

    // The first two samples are registered at PRESCALE/2-1 and PRESCALE/2.
    // The third one (PRESCALE/2+1) is voted directly from rx_s in the cycle it
    // is taken, so the bit decision is committed on that same edge. This keeps
    // the decision inside the bit even at the minimum PRESCALE of 4.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_early_sample
            localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(PRESCALE / 2 - 1 + gi);
            always_ff @(posedge CLK) begin
                if (RST) begin
                    early_sample_reg[gi] <= 1'b1;
                end else if (count_en && (edge_cnt_reg == CNT_CAP)) begin
                    early_sample_reg[gi] <= rx_s;
                end
            end
        end
    endgenerate

    assign sample_done = count_en && (edge_cnt_reg == CNT_CAP2);
    assign sample_bit  = (early_sample_reg[0] & early_sample_reg[1]) |
                         (early_sample_reg[0] & rx_s) |
                         (early_sample_reg[1] & rx_s);
    assign bit_end     = count_en && (edge_cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART serial receiver. Frame: start(0), DATA_WIDTH data bits LSB first,
// optional parity bit, stop(1). PRESCALE clocks per bit, same clock as TX.
//
// Ports:
//   CLK         clock
//   RST         synchronous active-high reset
//   RX_IN       serial line, idles high
//   PAR_EN      1 = frame carries a parity bit (latched at start of data)
//   PAR_TYP     0 = even, 1 = odd (latched at start of data)
//   P_DATA      last correctly received word
//   Data_Valid  one-cycle pulse on a good frame
//   PAR_ERR     one-cycle pulse at end of frame on parity mismatch
//   STP_ERR     one-cycle pulse at end of frame when stop bit sampled 0
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int BCNT_W = $clog2(DATA_WIDTH + 1);

    // Two-flop synchroniser, resets to the idle line level.
    logic [1:0] sync_reg;
    logic       rx_s;

    uart_state_t           state_reg, state_next;
    logic [BCNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  par_en_reg, par_en_next;
    logic                  par_typ_reg, par_typ_next;
    logic                  par_err_flag_reg, par_err_flag_next;
    logic                  stp_err_flag_reg, stp_err_flag_next;
    logic [DATA_WIDTH-1:0] p_data_reg, p_data_next;
    logic                  data_valid_reg, data_valid_next;
    logic                  par_err_reg, par_err_next;
    logic                  stp_err_reg, stp_err_next;

    logic                  count_en;
    logic                  clear;
    logic                  sample_done;
    logic                  sample_bit;
    logic                  bit_end;
    logic [PARITY_MAX_WIDTH-1:0] par_word;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], RX_IN};
        end
    end

    assign rx_s = sync_reg[1];

    // The counter runs throughout a frame, and also in the IDLE cycle that
    // first sees the line low: that cycle is edge 0 of the start bit.
    assign count_en = (state_reg != IDLE) || !rx_s;

    uart_rx_bit_sampler #(
        .PRESCALE(PRESCALE)
    ) u_bit_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .rx_s       (rx_s),
        .count_en   (count_en),
        .clear      (clear),
        .sample_done(sample_done),
        .sample_bit (sample_bit),
        .bit_end    (bit_end)
    );

    always_comb begin
        par_word                 = '0;
        par_word[DATA_WIDTH-1:0] = shift_reg;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            par_en_reg       <= 1'b0;
            par_typ_reg      <= 1'b0;
            par_err_flag_reg <= 1'b0;
            stp_err_flag_reg <= 1'b0;
            p_data_reg       <= '0;
            data_valid_reg   <= 1'b0;
            par_err_reg      <= 1'b0;
            stp_err_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            bit_cnt_reg      <= bit_cnt_next;
            shift_reg        <= shift_next;
            par_en_reg       <= par_en_next;
            par_typ_reg      <= par_typ_next;
            par_err_flag_reg <= par_err_flag_next;
            stp_err_flag_reg <= stp_err_flag_next;
            p_data_reg       <= p_data_next;
            data_valid_reg   <= data_valid_next;
            par_err_reg      <= par_err_next;
            stp_err_reg      <= stp_err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        bit_cnt_next      = bit_cnt_reg;
        shift_next        = shift_reg;
        par_en_next       = par_en_reg;
        par_typ_next      = par_typ_reg;
        par_err_flag_next = par_err_flag_reg;
        stp_err_flag_next = stp_err_flag_reg;
        p_data_next       = p_data_reg;
        data_valid_next   = 1'b0;
        par_err_next      = 1'b0;
        stp_err_next      = 1'b0;
        clear             = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end

            START: begin
                if (sample_done && sample_bit) begin
                    // Line was back high at mid-bit: a glitch, not a start bit.
                    state_next = IDLE;
                    clear      = 1'b1;
                end else if (bit_end) begin
                    state_next        = DATA;
                    bit_cnt_next      = '0;
                    par_en_next       = PAR_EN;
                    par_typ_next      = PAR_TYP;
                    par_err_flag_next = 1'b0;
                    stp_err_flag_next = 1'b0;
                end
            end

            DATA: begin
                if (sample_done) begin
                    shift_next   = {sample_bit, shift_reg[DATA_WIDTH-1:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
                if (bit_end && (bit_cnt_next == BCNT_W'(DATA_WIDTH))) begin
                    state_next   = par_en_reg ? PARITY : STOP;
                    bit_cnt_next = '0;
                end
            end

            PARITY: begin
                if (sample_done && (sample_bit != calc_parity(par_word, par_typ_reg))) begin
                    par_err_flag_next = 1'b1;
                end
                if (bit_end) begin
                    state_next = STOP;
                end
            end

            STOP: begin
                if (sample_done && !sample_bit) begin
                    stp_err_flag_next = 1'b1;
                end
                if (bit_end) begin
                    // The _next flags are used so a stop sample that lands on
                    // the last edge (PRESCALE = 4) still counts.
                    state_next = IDLE;
                    if (par_err_flag_next || stp_err_flag_next) begin
                        par_err_next = par_err_flag_next;
                        stp_err_next = stp_err_flag_next;
                    end else begin
                        data_valid_next = 1'b1;
                        p_data_next     = shift_reg;
                    end
                    par_err_flag_next = 1'b0;
                    stp_err_flag_next = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign P_DATA     = p_data_reg;
    assign Data_Valid = data_valid_reg;
    assign PAR_ERR    = par_err_reg;
    assign STP_ERR    = stp_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at PRESCALE=8, DATA_WIDTH=8. Inputs are driven
// on the falling edge; outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_ERR;
    logic       STP_ERR;

    int tests = 0;
    int fails = 0;

    // Rising edges seen so far; an edge index in the same numbering as E0.
    int cyc = 0;
    int e0  = 0;

    // Pulse monitor: counts high cycles of each outcome and remembers when.
    int         dv_cnt       = 0;
    int         pe_cnt       = 0;
    int         se_cnt       = 0;
    int         dv_cyc_last  = 0;
    int         dv_cyc_prev  = 0;
    int         pe_cyc_last  = 0;
    int         se_cyc_last  = 0;
    logic [7:0] dv_data_last = 8'h00;
    logic [7:0] dv_data_prev = 8'h00;

    uart_rx #(
        .DATA_WIDTH(8),
        .PRESCALE  (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_ERR   (PAR_ERR),
        .STP_ERR   (STP_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (Data_Valid) begin
            dv_cnt       <= dv_cnt + 1;
            dv_cyc_prev  <= dv_cyc_last;
            dv_cyc_last  <= cyc;
            dv_data_prev <= dv_data_last;
            dv_data_last <= P_DATA;
        end
        if (PAR_ERR) begin
            pe_cnt      <= pe_cnt + 1;
            pe_cyc_last <= cyc;
        end
        if (STP_ERR) begin
            se_cnt      <= se_cnt + 1;
            se_cyc_last <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (8) @(negedge CLK);
    endtask

    // Called on a falling edge; the next rising edge is E0.
    task automatic send_frame(input logic [7:0] d, input logic has_par,
                              input logic par_bit, input logic stop_bit);
        e0 = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par_bit);
        drive_bit(stop_bit);
        RX_IN = 1'b1;
        $display("[TB] frame data=0x%02h par_en=%0b par_bit=%0b stop=%0b E0=%0d",
                 d, has_par, par_bit, stop_bit, e0);
    endtask

    initial begin
        RST     = 1'b1;
        RX_IN   = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_p_data", 32'(P_DATA), 32'h0);
        check("rst_dv", 32'(Data_Valid), 32'h0);
        check("rst_par_err", 32'(PAR_ERR), 32'h0);
        check("rst_stp_err", 32'(STP_ERR), 32'h0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // 1: no parity, 0xC8
        PAR_EN = 1'b0;
        send_frame(8'hC8, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        check("t1_dv_count", 32'(dv_cnt), 32'd1);
        check("t1_dv_latency", 32'(dv_cyc_last - e0), 32'd81);
        check("t1_p_data", 32'(P_DATA), 32'hC8);
        check("t1_par_err_count", 32'(pe_cnt), 32'd0);
        check("t1_stp_err_count", 32'(se_cnt), 32'd0);

        // 2: odd parity, 0xA1 has three ones so the parity bit is 0
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b1;
        send_frame(8'hA1, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        check("t2_dv_count", 32'(dv_cnt), 32'd2);
        check("t2_dv_latency", 32'(dv_cyc_last - e0), 32'd89);
        check("t2_p_data", 32'(P_DATA), 32'hA1);
        send_frame(8'hA1, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge CLK);
        check("t2b_par_err_count", 32'(pe_cnt), 32'd1);
        check("t2b_par_err_latency", 32'(pe_cyc_last - e0), 32'd89);
        check("t2b_dv_count", 32'(dv_cnt), 32'd2);
        check("t2b_p_data_held", 32'(P_DATA), 32'hA1);
        check("t2b_stp_err_count", 32'(se_cnt), 32'd0);

        // 3: even parity, 0xF3 has six ones so parity 0 is correct; stop bit 0
        PAR_TYP = 1'b0;
        send_frame(8'hF3, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge CLK);
        check("t3_stp_err_count", 32'(se_cnt), 32'd1);
        check("t3_stp_err_latency", 32'(se_cyc_last - e0), 32'd89);
        check("t3_par_err_count", 32'(pe_cnt), 32'd1);
        check("t3_dv_count", 32'(dv_cnt), 32'd2);
        check("t3_p_data_held", 32'(P_DATA), 32'hA1);

        // 4: two-clock glitch, then a real frame
        PAR_EN = 1'b0;
        RX_IN  = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        $display("[TB] glitch low for 2 clocks");
        repeat (20) @(negedge CLK);
        check("t4_glitch_dv", 32'(dv_cnt), 32'd2);
        check("t4_glitch_par_err", 32'(pe_cnt), 32'd1);
        check("t4_glitch_stp_err", 32'(se_cnt), 32'd1);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        check("t4_dv_count", 32'(dv_cnt), 32'd3);
        check("t4_dv_latency", 32'(dv_cyc_last - e0), 32'd81);
        check("t4_p_data", 32'(P_DATA), 32'h33);

        // 5: back-to-back frames with no idle gap
        send_frame(8'h28, 1'b0, 1'b0, 1'b1);
        send_frame(8'h31, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        check("t5_dv_count", 32'(dv_cnt), 32'd5);
        check("t5_first_data", 32'(dv_data_prev), 32'h28);
        check("t5_second_data", 32'(dv_data_last), 32'h31);
        check("t5_spacing", 32'(dv_cyc_last - dv_cyc_prev), 32'd80);
        check("t5_second_latency", 32'(dv_cyc_last - e0), 32'd81);

        // 6: reset during data bit 3 of 0xFA (bits LSB first 0,1,0,1,1,1,1,1)
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        $display("[TB] reset pulse during data bit 3");
        check("t6_rst_p_data", 32'(P_DATA), 32'h0);
        check("t6_rst_dv", 32'(Data_Valid), 32'h0);
        check("t6_rst_par_err", 32'(PAR_ERR), 32'h0);
        check("t6_rst_stp_err", 32'(STP_ERR), 32'h0);
        repeat (4 + 4 * 8 + 8 + 20) @(negedge CLK);
        check("t6_broken_dv", 32'(dv_cnt), 32'd5);
        check("t6_broken_par_err", 32'(pe_cnt), 32'd1);
        check("t6_broken_stp_err", 32'(se_cnt), 32'd1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        check("t6_dv_count", 32'(dv_cnt), 32'd6);
        check("t6_p_data", 32'(P_DATA), 32'h5A);
        check("t6_dv_latency", 32'(dv_cyc_last - e0), 32'd81);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
